muldiv_unit: RTL and testbench

- Iterative RV32M/RV64M multiply/divide unit for the next-generation pipelined core; sits beside the EX-stage ALU.
- Accepts one operation per handshake and computes it over multiple cycles; the core holds IF/ID/EX while busy.
- Returns the result and destination register address to EX/MEM through a valid/ready handshake.
- Supports a flush input to kill an in-flight op when a branch or jump is taken.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_div_step.sv | 23 ++
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and constants for muldiv_unit.
// Shared by the top and the divide-step sub-module.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Most-negative two's-complement value of width w (w <= 64).
  function automatic logic [63:0] min_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one restoring-division step.
// Trial-subtracts the divisor; keeps the difference when it does not borrow.
module muldiv_div_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   part_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] diff;

  // Trial subtraction; a clear top bit means no borrow.
  always_comb begin
    diff  = part_i - {1'b0, dvsr_i};
    q_o   = ~diff[XLEN];
    rem_o = q_o ? diff[XLEN-1:0] : part_i[XLEN-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide beside the EX ALU.
// Define MULDIV_FAST_MUL_EN for single-cycle multiply; divide stays iterative.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int W2    = 2 * XLEN;
  localparam logic [63:0]     MIN64   = min_neg(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = MIN64[XLEN-1:0];

  state_t          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic            negr_q;
  logic [XLEN-1:0] opnd_q;
  logic [W2-1:0]   prod_q;
  logic [XLEN-1:0] res_q;
  logic            valid_q;

  logic            sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, ovf;
  logic [XLEN-1:0] spec_res;

  logic [XLEN:0]   add_sum;
  logic [W2-1:0]   mul_nx, div_nx;
  logic [XLEN-1:0] rem_nx;
  logic            q_bit;

  logic [W2-1:0]   prod_sgn;
  logic [XLEN-1:0] rem_v, quo_v;
  logic [XLEN-1:0] fix_res;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = valid_q;
  assign result    = res_q;
  assign rd_out    = rd_q;

  // Operand signedness, magnitudes and special-case detection at accept.
  always_comb begin
    sgn_a = (op == OP_MULH) || (op == OP_MULHSU) ||
            (op == OP_DIV)  || (op == OP_REM);
    sgn_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg = sgn_a & src_a[XLEN-1];
    b_neg = sgn_b & src_b[XLEN-1];
    mag_a = a_neg ? (~src_a + 1'b1) : src_a;
    mag_b = b_neg ? (~src_b + 1'b1) : src_b;
    div_zero = op[2] && (src_b == '0);
    ovf = ((op == OP_DIV) || (op == OP_REM)) &&
          (src_a == MIN_NEG) && (src_b == '1);
    spec_res = '0;
    if (div_zero)
      spec_res = op[1] ? src_a : '1;
    else if (ovf)
      spec_res = op[1] ? '0 : src_a;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [W2-1:0]   fast_mag, fast_prod;
  logic [XLEN-1:0] fast_res;

  // Full-width product formed in the accept cycle.
  always_comb begin
    fast_mag  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    fast_prod = (a_neg ^ b_neg) ? (~fast_mag + 1'b1) : fast_mag;
    fast_res  = (op == OP_MUL) ? fast_prod[XLEN-1:0]
                               : fast_prod[W2-1:XLEN];
  end
`endif

  muldiv_div_step #(.XLEN(XLEN)) u_step (
    .part_i (prod_q[W2-1:XLEN-1]),
    .dvsr_i (opnd_q),
    .rem_o  (rem_nx),
    .q_o    (q_bit)
  );

  // Next product/remainder for one iteration of either algorithm.
  always_comb begin
    add_sum = {1'b0, prod_q[W2-1:XLEN]} + {1'b0, opnd_q};
    mul_nx  = prod_q[0] ? {add_sum, prod_q[XLEN-1:1]}
                        : {1'b0, prod_q[W2-1:1]};
    div_nx  = {rem_nx, prod_q[XLEN-2:0], q_bit};
  end

  // Sign correction and half selection for the final result.
  always_comb begin
    prod_sgn = neg_q ? (~prod_q + 1'b1) : prod_q;
    rem_v    = prod_q[W2-1:XLEN];
    quo_v    = prod_q[XLEN-1:0];
    fix_res  = '0;
    unique case (1'b1)
      (op_q == OP_MUL):
        fix_res = prod_sgn[XLEN-1:0];
      (!op_q[2] && op_q != OP_MUL):
        fix_res = prod_sgn[W2-1:XLEN];
      (op_q[2] && op_q[1]):
        fix_res = negr_q ? (~rem_v + 1'b1) : rem_v;
      (op_q[2] && !op_q[1]):
        fix_res = neg_q ? (~quo_v + 1'b1) : quo_v;
    endcase
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      opnd_q  <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid && !flush) begin
            op_q   <= op;
            rd_q   <= rd_in;
            neg_q  <= a_neg ^ b_neg;
            negr_q <= a_neg;
            cnt_q  <= CNT_W'(XLEN);
            if (div_zero || ovf) begin
              res_q   <= spec_res;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!op[2]) begin
              res_q   <= fast_res;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end
`endif
            else begin
              state_q <= S_CALC;
              if (op[2]) begin
                opnd_q <= mag_b;
                prod_q <= {{XLEN{1'b0}}, mag_a};
              end else begin
                opnd_q <= mag_a;
                prod_q <= {{XLEN{1'b0}}, mag_b};
              end
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            prod_q <= op_q[2] ? div_nx : mul_nx;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1))
              state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            res_q   <= fix_res;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush || out_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit.
// Expected values come from a plain-arithmetic RISC-V M model.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  rd_in = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .rd_in     (rd_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_out    (rd_out),
    .busy      (busy)
  );

  function automatic logic [31:0] ref_res(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, ua, ub;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = int'(a);
    ib = int'(b);
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 &&
        b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return XLEN + 2;
  endfunction

  // Issue one op from IDLE, wait for the result, hold, then accept it.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input int hold, output logic [31:0] res,
                       output logic [4:0] rdo, output int lat);
    op = f; src_a = a; src_b = b; rd_in = rd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    rdo = rd_out;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        result !== 32'h0 || rd_out !== 5'h0) begin
      bad++;
      $display("FAIL reset_init: ov=%b ir=%b busy=%b res=%h rd=%h want 0 1 0 0 0",
               out_valid, in_ready, busy, result, rd_out);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    op = 3'd5; src_a = 32'd1000; src_b = 32'd3; rd_in = 5'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        result !== 32'h0 || rd_out !== 5'h0) begin
      bad++;
      $display("FAIL reset_mid: ov=%b ir=%b busy=%b res=%h rd=%h want 0 1 0 0 0",
               out_valid, in_ready, busy, result, rd_out);
    end
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_stale: out_valid seen=%b want 0", seen);
    end
  endtask

  task automatic run_table(input string nm, input logic [2:0] f[4],
                           input logic [31:0] a[4], input logic [31:0] b[4],
                           input logic [31:0] e[4]);
    logic [31:0] r;
    logic [4:0]  ro;
    int          l;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], 5'(i + 3), 0, r, ro, l);
      total++;
      if (r !== e[i]) begin
        bad++;
        $display("FAIL %s_res[%0d]: got %h want %h", nm, i, r, e[i]);
      end
      total++;
      if (ro !== 5'(i + 3)) begin
        bad++;
        $display("FAIL %s_rd[%0d]: got %0d want %0d", nm, i, ro, i + 3);
      end
      total++;
      if (l != ref_lat(f[i], a[i], b[i])) begin
        bad++;
        $display("FAIL %s_lat[%0d]: got %0d want %0d", nm, i, l,
                 ref_lat(f[i], a[i], b[i]));
      end
    end
  endtask

  task automatic test_mul();
    run_table("mul",
      '{3'd0, 3'd1, 3'd3, 3'd2},
      '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF});
  endtask

  task automatic test_div();
    run_table("div",
      '{3'd4, 3'd6, 3'd5, 3'd7},
      '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100},
      '{32'd2, 32'd2, 32'd7, 32'd7},
      '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2});
  endtask

  task automatic test_special();
    run_table("spec",
      '{3'd4, 3'd7, 3'd4, 3'd6},
      '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000},
      '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0});
  endtask

  task automatic test_backpressure();
    logic [31:0] r0;
    logic [4:0]  d0;
    int          l;
    op = 3'd5; src_a = 32'd100; src_b = 32'd7; rd_in = 5'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    while (out_valid !== 1'b1 && l < 200) begin @(posedge clk); #1; l++; end
    r0 = result;
    d0 = rd_out;
    total++;
    if (r0 !== 32'd14 || d0 !== 5'd9) begin
      bad++;
      $display("FAIL bp_res: got %h/%0d want 0000000e/9", r0, d0);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || result !== r0 || rd_out !== d0 ||
          in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: ov=%b res=%h rd=%0d ir=%b want 1 %h %0d 0",
                 i, out_valid, result, rd_out, in_ready, r0, d0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: ov=%b ir=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_flush();
    logic        seen;
    logic [31:0] r;
    logic [4:0]  ro;
    int          l;
    op = 3'd4; src_a = 32'd1234; src_b = 32'd5; rd_in = 5'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_calc: ir=%b busy=%b ov=%b want 1 0 0",
               in_ready, busy, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL flush_calc_nores: seen=%b want 0", seen);
    end
    op = 3'd7; src_a = 32'd9; src_b = 32'd0; rd_in = 5'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL flush_done_pre: ov=%b want 1", out_valid);
    end
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_done: ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    op = 3'd5; src_a = 32'd50; src_b = 32'd5; rd_in = 5'd8;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle: ir=%b busy=%b ov=%b want 1 0 0",
               in_ready, busy, out_valid);
    end
    do_op(3'd5, 32'd9, 32'd3, 5'd12, 0, r, ro, l);
    total++;
    if (r !== 32'd3 || ro !== 5'd12 || l != XLEN + 2) begin
      bad++;
      $display("FAIL flush_after: got %h/%0d lat %0d want 3/12 lat %0d",
               r, ro, l, XLEN + 2);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, r;
    logic [4:0]  rd, ro;
    int          l;
    for (int i = 0; i < 150; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      rd = 5'($urandom);
      do_op(f, a, b, rd, $urandom_range(0, 3), r, ro, l);
      total++;
      if (r !== ref_res(f, a, b) || ro !== rd || l != ref_lat(f, a, b)) begin
        bad++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: got %h/%0d lat %0d want %h/%0d lat %0d",
                 i, f, a, b, r, ro, l, ref_res(f, a, b), rd, ref_lat(f, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
